// File: rtl/dsp_pkg.sv
// Shared types for the filter-chain control blocks: controller state encoding,
// a default packed tap-bank type and a counter-width helper.
package dsp_pkg;

    localparam int TAP_WIDTH = 16;
    localparam int TAP_LEN   = 21;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        SETTLE = 2'd2
    } ctrl_state_e;

    typedef logic [TAP_LEN-1:0][TAP_WIDTH-1:0] tap_bank_t;

    // Width needed to hold n-1; never less than one bit so settle = 0/1 still elaborates.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cke_counter.sv
// Loadable down-counter that steps only on enabled strobes and flags zero.
// Holds at zero rather than wrapping.
module cke_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tap_bank_ctrl.sv
// Shadow/active coefficient bank controller: host writes land in the shadow bank,
// a commit swaps it into the active bank on the next sample strobe, then busy settles.
module tap_bank_ctrl
    import dsp_pkg::*;
#(
    parameter int width   = 16,
    parameter int tap_len = 21,
    parameter int settle  = 21,
    parameter logic [tap_len-1:0][width-1:0] INIT_TAP = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cke,
    input  logic                             wr_en,
    input  logic [$clog2(tap_len)-1:0]       wr_addr,
    input  logic [width-1:0]                 wr_data,
    input  logic                             commit,
    output logic [tap_len-1:0][width-1:0]    tap,
    output logic                             busy,
    output logic                             swap_pulse,
    output logic                             err,
    output logic [7:0]                       bank_gen
);

    localparam int AW = $clog2(tap_len);
    localparam int CW = cnt_width(settle);
    localparam logic [CW-1:0] SETTLE_LOAD = (settle > 0) ? CW'(settle - 1) : '0;

    ctrl_state_e                    state_q, state_d;
    logic [tap_len-1:0][width-1:0]  shadow_q, shadow_d;
    logic [tap_len-1:0][width-1:0]  active_q, active_d;
    logic                           swap_q, swap_d;
    logic                           err_q, err_d;
    logic [7:0]                     gen_q, gen_d;
    logic                           cnt_load;
    logic                           cnt_dec;
    logic                           cnt_zero;

    cke_counter #(
        .W(CW)
    ) u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        swap_d   = 1'b0;
        err_d    = err_q;
        gen_d    = gen_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    if (int'(wr_addr) < tap_len) begin
                        for (int i = 0; i < tap_len; i++) begin
                            if (wr_addr == AW'(i)) begin
                                shadow_d[i] = wr_data;
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (commit) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                // Entered the edge after commit, so a strobe coincident with commit never lands here.
                if (cke) begin
                    active_d = shadow_q;
                    swap_d   = 1'b1;
                    gen_d    = gen_q + 8'd1;
                    if (settle > 0) begin
                        state_d  = SETTLE;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SETTLE: begin
                if (cke) begin
                    if (cnt_zero) begin
                        state_d = IDLE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && (wr_en || commit)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= INIT_TAP;
            active_q <= INIT_TAP;
            swap_q   <= 1'b0;
            err_q    <= 1'b0;
            gen_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            swap_q   <= swap_d;
            err_q    <= err_d;
            gen_q    <= gen_d;
        end
    end

    assign tap        = active_q;
    assign busy       = (state_q != IDLE);
    assign swap_pulse = swap_q;
    assign err        = err_q;
    assign bank_gen   = gen_q;

endmodule
